// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OPCODE_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [WORD_W-1:0]   NOP                 = 32'h0;
    localparam logic [OPCODE_W-1:0] DEFAULT_HALT_OPCODE = 6'h3F;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [WORD_W-1:0] address;
    } if_id_t;

    localparam if_id_t IF_ID_NOP = '{instruction: NOP, address: 32'h0};

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, program-load and observation signals of the fetch stage.
interface instruction_fetch_if #(
    parameter int unsigned MEM_DEPTH = 1024
);
    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

    logic              inStart;
    logic              inPC_write;
    logic              inIF_ID_write;
    logic              inJumpTake;
    logic [31:0]       inAddress_jump;
    logic              inBranchTake;
    logic [31:0]       inAddress_branch;
    logic              stop_debug;
    logic              inProg_wr;
    logic [ADDR_W-1:0] inProg_addr;
    logic [31:0]       inProg_data;
    logic [31:0]       outInstructionAddress;
    logic [31:0]       outInstruction;
    logic [31:0]       outPC;
    logic              outHalt;
    logic [31:0]       outCycles;

    modport master (
        output inStart, inPC_write, inIF_ID_write, inJumpTake, inAddress_jump,
               inBranchTake, inAddress_branch, stop_debug, inProg_wr, inProg_addr, inProg_data,
        input  outInstructionAddress, outInstruction, outPC, outHalt, outCycles
    );

    modport slave (
        input  inStart, inPC_write, inIF_ID_write, inJumpTake, inAddress_jump,
               inBranchTake, inAddress_branch, stop_debug, inProg_wr, inProg_addr, inProg_data,
        output outInstructionAddress, outInstruction, outPC, outHalt, outCycles
    );

endinterface

// File: rtl/instruction_fetch_memory.sv
// Instruction memory: one synchronous write port, one combinational read port.
module instruction_memory #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [31:0]       wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [31:0]       rdData
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC sequencing with branch/jump/stall/debug control, IF/ID register,
// halt detection and run-cycle counter.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned          MEM_DEPTH   = 1024,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic         clk,
    input  logic         rst,
    instruction_fetch_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

    fetch_state_t state, stateNext;
    logic [WORD_W-1:0] pc, pcNext;
    logic [WORD_W-1:0] cycles, cyclesNext;
    if_id_t            ifId, ifIdNext;
    logic              halt;
    logic [WORD_W-1:0] memData;
    logic              memWrite;

    // Program load is only honoured while idle
    assign memWrite = (state == IDLE) && bus.inProg_wr && !rst;

    instruction_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .wrEn   (memWrite),
        .wrAddr (bus.inProg_addr),
        .wrData (bus.inProg_data),
        .rdAddr (pc[ADDR_W-1:0]),
        .rdData (memData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            ifId   <= IF_ID_NOP;
            cycles <= '0;
            halt   <= 1'b0;
        end else begin
            state  <= stateNext;
            pc     <= pcNext;
            ifId   <= ifIdNext;
            cycles <= cyclesNext;
            halt   <= (stateNext == HALT);
        end
    end

    // Redirects beat stalls; a halt opcode only counts when it really enters IF/ID
    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        ifIdNext   = ifId;
        cyclesNext = cycles;
        unique case (state)
            IDLE: begin
                pcNext   = '0;
                ifIdNext = IF_ID_NOP;
                if (bus.inStart) stateNext = RUN;
            end
            RUN: begin
                if (!bus.stop_debug) begin
                    cyclesNext = cycles + 32'd1;
                    if (bus.inBranchTake) begin
                        pcNext   = bus.inAddress_branch;
                        ifIdNext = IF_ID_NOP;
                    end else if (bus.inJumpTake) begin
                        pcNext   = bus.inAddress_jump;
                        ifIdNext = IF_ID_NOP;
                    end else begin
                        if (bus.inPC_write) pcNext = pc + 32'd1;
                        if (bus.inIF_ID_write) begin
                            ifIdNext = '{instruction: memData, address: pc + 32'd1};
                            if (memData[31:26] == HALT_OPCODE) stateNext = HALT;
                        end
                    end
                end
            end
            HALT: begin
                ifIdNext = IF_ID_NOP;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.outPC                 = pc;
    assign bus.outInstruction        = ifId.instruction;
    assign bus.outInstructionAddress = ifId.address;
    assign bus.outHalt               = halt;
    assign bus.outCycles             = cycles;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter HALT_OPCODE, default 6'h3F, opcode bits [31:26] that stop fetch.
REQ-003 Ports (name direction width meaning):
- clk in 1: single clock, all state updates on rising edge.
- rst in 1: synchronous reset, active-high.
- inStart in 1: leave IDLE and begin fetching.
- inPC_write in 1: 0 holds PC (load-use stall from decode hazard unit).
- inIF_ID_write in 1: 0 holds the IF/ID register.
- inJumpTake in 1: jump resolved in decode this cycle.
- inAddress_jump in 32: jump target (word address).
- inBranchTake in 1: branch resolved downstream this cycle; also drives decode ID_flush externally.
- inAddress_branch in 32: branch target (word address).
- stop_debug in 1: freeze all state.
- inProg_wr in 1: program-load write strobe.
- inProg_addr in log2(MEM_DEPTH): program-load word address.
- inProg_data in 32: program-load word.
- outInstructionAddress out 32: PC+1 of the latched instruction.
- outInstruction out 32: latched instruction (IF/ID).
- outPC out 32: current PC.
- outHalt out 1: halt state reached.
- outCycles out 32: count of RUN cycles.

Function
REQ-004 PC SHALL be word-addressed; sequential next PC = PC+1, modulo 2^32.
REQ-005 Memory index SHALL be PC[log2(MEM_DEPTH)-1:0]; addresses beyond depth wrap.
REQ-006 Memory read SHALL be combinational; memory write SHALL be synchronous.
REQ-007 The FSM SHALL have states IDLE, RUN and HALT.
REQ-008 IDLE: PC = 0, IF/ID = NOP (32'h0), inProg_wr writes memory; inStart=1 -> RUN next edge.
REQ-009 inProg_wr SHALL be ignored outside IDLE.
REQ-010 RUN: per-edge priority for PC and IF/ID: stop_debug > inBranchTake > inJumpTake > stall > normal.
REQ-011 stop_debug=1: PC, IF/ID, state and outCycles all hold.
REQ-012 inBranchTake=1: PC <= inAddress_branch; IF/ID <= NOP with outInstructionAddress = 0; stall inputs ignored.
REQ-013 inJumpTake=1 with inBranchTake=0: PC <= inAddress_jump; IF/ID <= NOP; stall inputs ignored.
REQ-014 Stall: inPC_write=0 holds PC; inIF_ID_write=0 holds IF/ID; each input acts independently.
REQ-015 Normal: PC <= PC+1; IF/ID <= {mem[PC], PC+1}.
REQ-016 Halt entry: when the instruction loaded into IF/ID has opcode HALT_OPCODE, state -> HALT on that same edge.
REQ-017 Halt entry SHALL NOT occur if that load is overridden by branch, jump or stall.
REQ-018 HALT: PC holds; IF/ID <= NOP on the next edge and every edge after; outHalt=1.
REQ-019 HALT SHALL be left only by rst.
REQ-020 outCycles SHALL increment by 1 on each edge in RUN with stop_debug=0, and hold in IDLE and HALT.
REQ-021 outCycles SHALL wrap at 2^32.
REQ-022 Fetch latency: instruction at address A appears on outInstruction one edge after PC = A.

Reset
REQ-023 rst=1 at a rising edge SHALL set: state IDLE; PC = 0; outInstruction = 0; outInstructionAddress = 0; outHalt = 0; outCycles = 0.
REQ-024 Memory contents SHALL be preserved across reset.
REQ-025 rst SHALL override every other input, including stop_debug, in any state.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, NOP (32'h0) and the default HALT_OPCODE.
REQ-027 The memory SHALL be a sub-module instruction_memory (MEM_DEPTH x 32, one write port, one async read port).

Verification
REQ-028 Program load and run: load words 0..3 with opcode-0 instructions, word 4 = 32'hFC000000; pulse inStart -> outInstruction shows words 0..4 on consecutive edges; outHalt=1 on the edge word 4 loads; outCycles = 5; PC frozen at 5.
REQ-029 Load-use stall: inPC_write=0 and inIF_ID_write=0 for 1 cycle at PC=2 -> PC stays 2 and IF/ID holds word 1 for one extra edge; fetch then resumes at word 2.
REQ-030 Simultaneous branch, jump and stall: inBranchTake=1 (target 40), inJumpTake=1 (target 80), inPC_write=0 on the same edge -> PC = 40 and outInstruction = 0; next edge fetches word 40.
REQ-031 Jump: inJumpTake=1, target 7, at PC=3 -> IF/ID = NOP; next edge outInstruction = mem[7] and outInstructionAddress = 8.
REQ-032 Debug freeze: stop_debug=1 for 3 cycles mid-RUN -> PC, IF/ID and outCycles unchanged; inProg_wr during RUN leaves memory unchanged.
REQ-033 Reset mid-run: rst at PC=9 -> next edge state IDLE, all outputs 0, memory intact; inStart refetches from word 0.
